// File: rtl/arb2_mux_4b_pkg.sv
// Shared definitions for the two-requester round-robin arbiter/mux.
//   REQ0, REQ1   : requester index constants (also the mux select values)
//   out_state_t  : occupancy of the single-entry output register
package arb2_mux_4b_pkg;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } out_state_t;

endpackage

// File: rtl/mux2x1_4b.sv
// Plain 4-bit 2:1 multiplexer.
//   s  : select (0 -> d0, 1 -> d1)
//   d0 : data input 0
//   d1 : data input 1
//   y  : selected data
module mux2x1_4b (
    input  logic       s,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    output logic [3:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   clr_i      : synchronous clear, wins over inc_i
//   inc_i      : increment request, ignored at all-ones
//   cnt_o      : current count
module sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/arb2_mux_4b.sv
// Two-requester round-robin arbiter feeding a shared 2:1 mux and a
// single-entry registered output stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req{0,1}_valid_i    : requester has a word
//   req{0,1}_data_i     : requester word
//   req{0,1}_ready_o    : requester word accepted this cycle (combinational)
//   out_valid_o         : output register holds a word
//   out_data_o          : output word
//   out_src_o           : requester index that produced out_data_o
//   out_ready_i         : consumer takes the output word
//   mux_sel_o           : combinational mux select (0 = req0, 1 = req1)
//   cnt_clr_i           : synchronous clear of both grant counters
//   gnt_cnt{0,1}_o      : saturating grant counts per requester
module arb2_mux_4b
    import arb2_mux_4b_pkg::*;
#(
    parameter int unsigned DW = 4,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid_i,
    input  logic [DW-1:0] req0_data_i,
    output logic          req0_ready_o,
    input  logic          req1_valid_i,
    input  logic [DW-1:0] req1_data_i,
    output logic          req1_ready_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    output logic          out_src_o,
    input  logic          out_ready_i,
    output logic          mux_sel_o,
    input  logic          cnt_clr_i,
    output logic [CW-1:0] gnt_cnt0_o,
    output logic [CW-1:0] gnt_cnt1_o
);

    out_state_t    state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          src_q, src_d;
    logic          last_q, last_d;

    logic          can_load;
    logic          g0, g1;
    logic [DW-1:0] mux_out;

    assign can_load = (state_q == StEmpty) || out_ready_i;

    // last_q points at the previous winner, so a tie goes to the other one.
    assign g0 = can_load && req0_valid_i && (!req1_valid_i || (last_q == REQ1));
    assign g1 = can_load && req1_valid_i && (!req0_valid_i || (last_q == REQ0));

    assign req0_ready_o = g0;
    assign req1_ready_o = g1;

    // With no grant the select parks on the last winner.
    assign mux_sel_o = (g0 || g1) ? g1 : last_q;

    generate
        if (DW == 4) begin : g_mux_cell
            mux2x1_4b u_mux (
                .s  (mux_sel_o),
                .d0 (req0_data_i),
                .d1 (req1_data_i),
                .y  (mux_out)
            );
        end else begin : g_mux_inline
            assign mux_out = mux_sel_o ? req1_data_i : req0_data_i;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        if (g0 || g1) begin
            // Load replaces any word being unloaded in the same edge.
            state_d = StFull;
            data_d  = mux_out;
            src_d   = g1 ? REQ1 : REQ0;
            last_d  = g1 ? REQ1 : REQ0;
        end else if (out_ready_i) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
            src_q   <= REQ0;
            last_q  <= REQ1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    assign out_valid_o = (state_q == StFull);
    assign out_data_o  = data_q;
    assign out_src_o   = src_q;

    sat_cnt #(
        .W (CW)
    ) u_cnt0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_i),
        .inc_i (g0),
        .cnt_o (gnt_cnt0_o)
    );

    sat_cnt #(
        .W (CW)
    ) u_cnt1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_i),
        .inc_i (g1),
        .cnt_o (gnt_cnt1_o)
    );

endmodule

// File: tb/tb_arb2_mux_4b.sv
module tb_arb2_mux_4b;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_data, req1_data;
    logic       out_ready, cnt_clr;

    logic       req0_ready, req1_ready, out_valid, out_src, mux_sel;
    logic [3:0] out_data;
    logic [7:0] gnt_cnt0, gnt_cnt1;

    // Second instance with 2-bit counters, sharing all inputs.
    logic       s_req0_ready, s_req1_ready, s_out_valid, s_out_src, s_mux_sel;
    logic [3:0] s_out_data;
    logic [1:0] s_gnt_cnt0, s_gnt_cnt1;

    int n_cmp = 0;
    int n_err = 0;

    arb2_mux_4b dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid),
        .req0_data_i  (req0_data),
        .req0_ready_o (req0_ready),
        .req1_valid_i (req1_valid),
        .req1_data_i  (req1_data),
        .req1_ready_o (req1_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_src_o    (out_src),
        .out_ready_i  (out_ready),
        .mux_sel_o    (mux_sel),
        .cnt_clr_i    (cnt_clr),
        .gnt_cnt0_o   (gnt_cnt0),
        .gnt_cnt1_o   (gnt_cnt1)
    );

    arb2_mux_4b #(
        .DW (4),
        .CW (2)
    ) dut_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid),
        .req0_data_i  (req0_data),
        .req0_ready_o (s_req0_ready),
        .req1_valid_i (req1_valid),
        .req1_data_i  (req1_data),
        .req1_ready_o (s_req1_ready),
        .out_valid_o  (s_out_valid),
        .out_data_o   (s_out_data),
        .out_src_o    (s_out_src),
        .out_ready_i  (out_ready),
        .mux_sel_o    (s_mux_sel),
        .cnt_clr_i    (cnt_clr),
        .gnt_cnt0_o   (s_gnt_cnt0),
        .gnt_cnt1_o   (s_gnt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 4'h0;
        req1_data  = 4'h0;
        out_ready  = 1'b0;
        cnt_clr    = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 4'h0);
        chk("rst_out_src", out_src, 1'b0);
        chk("rst_cnt0", gnt_cnt0, 8'd0);
        chk("rst_cnt1", gnt_cnt1, 8'd0);
        chk("rst_mux_sel_last", mux_sel, 1'b1);

        // Single requester, one-cycle latency
        step();
        req0_valid = 1'b1;
        req0_data  = 4'hA;
        out_ready  = 1'b1;
        #1;
        chk("t1_req0_ready", req0_ready, 1'b1);
        chk("t1_req1_ready", req1_ready, 1'b0);
        chk("t1_mux_sel", mux_sel, 1'b0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_out_data", out_data, 4'hA);
        chk("t1_out_src", out_src, 1'b0);
        chk("t1_cnt0", gnt_cnt0, 8'd1);
        chk("t1_req0_ready_dropped", req0_ready, 1'b0);

        // Unload with no requesters: drains, data held
        step();
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_out_data_held", out_data, 4'hA);

        // Strict alternation from a fresh reset
        pulse_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 4'h3;
        req1_data  = 4'hC;
        out_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("t2_req0_ready_%0d", i), req0_ready, (i % 2 == 0));
            chk($sformatf("t2_req1_ready_%0d", i), req1_ready, (i % 2 == 1));
            step();
            chk($sformatf("t2_out_data_%0d", i), out_data, (i % 2 == 0) ? 4'h3 : 4'hC);
            chk($sformatf("t2_out_valid_%0d", i), out_valid, 1'b1);
        end
        chk("t2_cnt0", gnt_cnt0, 8'd3);
        chk("t2_cnt1", gnt_cnt1, 8'd3);

        // Backpressure while FULL
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t3_req0_ready_%0d", i), req0_ready, 1'b0);
            chk($sformatf("t3_req1_ready_%0d", i), req1_ready, 1'b0);
            step();
            chk($sformatf("t3_out_data_%0d", i), out_data, 4'hC);
            chk($sformatf("t3_out_valid_%0d", i), out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release_req0_ready", req0_ready, 1'b1);
        chk("t3_release_req1_ready", req1_ready, 1'b0);
        step();
        chk("t3_release_data", out_data, 4'h3);
        chk("t3_release_src", out_src, 1'b0);
        chk("t3_cnt0", gnt_cnt0, 8'd4);
        chk("t3_small_cnt0_sat", s_gnt_cnt0, 2'd3);

        // Saturation with 2-bit counters, then clear over a grant
        pulse_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        out_ready  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            req1_data = 4'(k);
            step();
            chk($sformatf("t4_out_data_%0d", k), out_data, 4'(k));
            chk($sformatf("t4_out_src_%0d", k), out_src, 1'b1);
            chk($sformatf("t4_small_cnt1_%0d", k), s_gnt_cnt1, (k > 3) ? 2'd3 : 2'(k));
            chk($sformatf("t4_cnt1_%0d", k), gnt_cnt1, 8'(k));
        end
        cnt_clr   = 1'b1;
        req1_data = 4'h6;
        step();
        cnt_clr = 1'b0;
        chk("t4_clr_out_data", out_data, 4'h6);
        chk("t4_clr_cnt1", gnt_cnt1, 8'd0);
        chk("t4_clr_small_cnt1", s_gnt_cnt1, 2'd0);

        // Asynchronous reset while FULL
        out_ready  = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("t5_pre_out_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_out_valid", out_valid, 1'b0);
        chk("t5_async_out_data", out_data, 4'h0);
        chk("t5_async_mux_sel", mux_sel, 1'b1);
        #1;
        rst_n      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 4'h5;
        req1_data  = 4'h9;
        out_ready  = 1'b1;
        #1;
        chk("t5_tie_req0_ready", req0_ready, 1'b1);
        chk("t5_tie_req1_ready", req1_ready, 1'b0);
        step();
        chk("t5_out_data", out_data, 4'h5);
        chk("t5_out_src", out_src, 1'b0);
        chk("t5_cnt0", gnt_cnt0, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
